// File: rtl/simd_proc_frontend_pkg.sv
// Shared types for the SIMD processor receive front end: instruction phases,
// the instruction beat carried from the issuer, and the front-end FSM states.
`ifndef INSTR_PAYLOAD_W
`define INSTR_PAYLOAD_W 32
`endif

package simd_proc_frontend_pkg;

    typedef enum logic [1:0] {
        LD1   = 2'd0,
        LD2   = 2'd1,
        INFO  = 2'd2,
        STORE = 2'd3
    } instr_kind_e;

    typedef struct packed {
        instr_kind_e                 kind;
        logic [`INSTR_PAYLOAD_W-1:0] payload;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_ACK_HOLD,
        ST_START,
        ST_RUN,
        ST_DONE
    } fe_state_e;

    // Phases arrive in enum order; STORE wraps back to LD1.
    function automatic instr_kind_e next_kind(input instr_kind_e k);
        return instr_kind_e'(k + 2'd1);
    endfunction

endpackage

// File: rtl/simd_fe_handshake.sv
// Four-phase level receiver: strobes a capture when an accepted beat arrives,
// holds ack until enable is seen low, and flags that en-low cycle.
module simd_fe_handshake (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_accept,
    output logic o_capture,
    output logic o_en_low,
    output logic o_ack
);

    logic ack_q;

    // Masking with ack_q keeps a held enable from re-capturing the same beat.
    assign o_capture = i_en & i_accept & ~ack_q;
    assign o_en_low  = ack_q & ~i_en;
    assign o_ack     = ack_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ack_q <= 1'b0;
        end else if (o_capture) begin
            ack_q <= 1'b1;
        end else if (o_en_low) begin
            ack_q <= 1'b0;
        end
    end

endmodule

// File: rtl/simd_proc_frontend.sv
// Per-slot receive stage behind the issuer: collects LD1/LD2/INFO/STORE,
// launches the core and holds finish until the issuer acknowledges it.
// Optional core watchdog: define SIMD_FE_TIMEOUT_EN.
module simd_proc_frontend
    import simd_proc_frontend_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned INFO_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  instr_t            i_instr,
    output logic              o_ack,
    output logic              o_busy,
    output logic              o_finish,
    input  logic              i_finish_ack,
    output logic              o_core_start,
    output logic [ADDR_W-1:0] o_core_op1,
    output logic [ADDR_W-1:0] o_core_op2,
    output logic [INFO_W-1:0] o_core_info,
    output logic [ADDR_W-1:0] o_core_wb,
    input  logic              i_core_done,
    output logic              o_err
);

    fe_state_e         state_q, state_d;
    instr_kind_e       ptr_q;
    logic [ADDR_W-1:0] op1_q, op2_q, wb_q;
    logic [INFO_W-1:0] info_q;
    logic              busy_q, err_q;
    logic              rx_state, kind_ok, proto_err;
    logic              capture, en_low;
    logic              tmo_hit;
    logic              unused_cfg;

    assign rx_state  = (state_q == ST_IDLE) || (state_q == ST_RX);
    assign kind_ok   = (i_instr.kind == ptr_q);
    assign proto_err = rx_state & i_en & ~kind_ok;

    simd_fe_handshake u_hs (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_en      (i_en),
        .i_accept  (rx_state & kind_ok),
        .o_capture (capture),
        .o_en_low  (en_low),
        .o_ack     (o_ack)
    );

`ifdef SIMD_FE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;

    // Counts from 0 in the START cycle, so the hit lands on the last RUN cycle
    // and finish appears exactly TIMEOUT_CYC cycles after START.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_START || state_q == ST_RUN) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit    = (state_q == ST_RUN) && !i_core_done &&
                        (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign unused_cfg = ^i_instr.payload;
`else
    assign tmo_hit    = 1'b0;
    assign unused_cfg = ^{i_instr.payload, TIMEOUT_CYC};
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RX: if (capture) state_d = ST_ACK_HOLD;
            ST_ACK_HOLD:    if (en_low) state_d = (ptr_q == STORE) ? ST_START : ST_RX;
            ST_START:       state_d = ST_RUN;
            ST_RUN:         if (i_core_done || tmo_hit) state_d = ST_DONE;
            ST_DONE:        if (i_finish_ack) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_core_start = 1'b0;
        o_finish     = 1'b0;
        case (state_q)
            ST_START: o_core_start = 1'b1;
            ST_DONE:  o_finish     = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q  <= LD1;
            op1_q  <= '0;
            op2_q  <= '0;
            info_q <= '0;
            wb_q   <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (capture) begin
                case (ptr_q)
                    LD1: begin
                        op1_q  <= i_instr.payload[ADDR_W-1:0];
                        busy_q <= 1'b1;
                    end
                    LD2:   op2_q  <= i_instr.payload[ADDR_W-1:0];
                    INFO:  info_q <= i_instr.payload[INFO_W-1:0];
                    STORE: wb_q   <= i_instr.payload[ADDR_W-1:0];
                    default: ;
                endcase
            end
            if (state_q == ST_ACK_HOLD && en_low) begin
                ptr_q <= next_kind(ptr_q);
            end
            if (state_q == ST_DONE && i_finish_ack) begin
                busy_q <= 1'b0;
                ptr_q  <= LD1;
            end
            if (proto_err || tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_err       = err_q;
    assign o_core_op1  = op1_q;
    assign o_core_op2  = op2_q;
    assign o_core_info = info_q;
    assign o_core_wb   = wb_q;

endmodule

// File: tb/tb_simd_proc_frontend.sv
// Directed bench for simd_proc_frontend: nominal task, stuck enable, phase
// error, finish handshake, async reset mid-run, optional watchdog.
module tb_simd_proc_frontend;
    import simd_proc_frontend_pkg::*;

`ifdef SIMD_FE_TIMEOUT_EN
    localparam int unsigned TCYC = 8;
`else
    localparam int unsigned TCYC = 1024;
`endif

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_en;
    instr_t      i_instr;
    logic        o_ack, o_busy, o_finish, i_finish_ack, o_core_start;
    logic [15:0] o_core_op1, o_core_op2, o_core_wb;
    logic [7:0]  o_core_info;
    logic        i_core_done, o_err;

    int n_checks = 0;
    int n_fail   = 0;

    simd_proc_frontend #(.ADDR_W(16), .INFO_W(8), .TIMEOUT_CYC(TCYC)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_en         (i_en),
        .i_instr      (i_instr),
        .o_ack        (o_ack),
        .o_busy       (o_busy),
        .o_finish     (o_finish),
        .i_finish_ack (i_finish_ack),
        .o_core_start (o_core_start),
        .o_core_op1   (o_core_op1),
        .o_core_op2   (o_core_op2),
        .o_core_info  (o_core_info),
        .o_core_wb    (o_core_wb),
        .i_core_done  (i_core_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input instr_kind_e k, input logic [31:0] p, input string tag);
        i_instr.kind    = k;
        i_instr.payload = p;
        i_en = 1'b1;
        tick();
        chk({tag, "_ack"}, {31'd0, o_ack}, 32'd1);
        i_en = 1'b0;
        tick();
        chk({tag, "_ackdrop"}, {31'd0, o_ack}, 32'd0);
    endtask

    task automatic load_task(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] inf, input logic [31:0] w, input string tag);
        send(LD1, a, {tag, "_ld1"});
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
        send(LD2, b, {tag, "_ld2"});
        send(INFO, inf, {tag, "_info"});
        send(STORE, w, {tag, "_store"});
        chk({tag, "_start"}, {31'd0, o_core_start}, 32'd1);
    endtask

    task automatic finish_task(input string tag);
        i_core_done = 1'b1;
        tick();
        i_core_done = 1'b0;
        chk({tag, "_finish"}, {31'd0, o_finish}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk({tag, "_finish_held"}, {31'd0, o_finish}, 32'd1);
        chk({tag, "_busy_held"}, {31'd0, o_busy}, 32'd1);
        i_finish_ack = 1'b1;
        tick();
        i_finish_ack = 1'b0;
        chk({tag, "_finish_clr"}, {31'd0, o_finish}, 32'd0);
        chk({tag, "_busy_clr"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
        tick();
    endtask

    initial begin
        i_rstn = 1'b0; i_en = 1'b0; i_instr = '0;
        i_finish_ack = 1'b0; i_core_done = 1'b0;
        tick();
        chk("rst_outs", {o_ack, o_busy, o_finish, o_core_start, o_err}, 32'd0);
        chk("rst_fields", {o_core_op1, o_core_op2} | {o_core_wb, 8'd0, o_core_info}, 32'd0);
        i_rstn = 1'b1;
        tick();

        // Stray done/finish-ack in IDLE must do nothing
        i_core_done = 1'b1; i_finish_ack = 1'b1;
        tick();
        i_core_done = 1'b0; i_finish_ack = 1'b0;
        chk("idle_ignore", {o_finish, o_busy, o_err}, 32'd0);

        // Nominal task; upper payload bits must be dropped
        load_task(32'h5A5A_0010, 32'h0000_0020, 32'h0000_FF05, 32'hFFFF_0030, "nom");
        chk("nom_op1", o_core_op1, 32'h0010);
        chk("nom_op2", o_core_op2, 32'h0020);
        chk("nom_info", o_core_info, 32'h05);
        chk("nom_wb", o_core_wb, 32'h0030);
        tick();
        chk("nom_start_pulse", {31'd0, o_core_start}, 32'd0);
        i_instr.kind = LD1; i_en = 1'b1;
        tick();
        chk("run_en_ignored", {31'd0, o_ack}, 32'd0);
        i_en = 1'b0;
        chk("run_op1_stable", o_core_op1, 32'h0010);
        finish_task("nom");

        // Stuck enable: held LD1 with changing payload is captured only once
        i_instr.kind = LD1; i_instr.payload = 32'h0011; i_en = 1'b1;
        tick();
        chk("stuck_ack", {31'd0, o_ack}, 32'd1);
        i_instr.payload = 32'h0099;
        for (int i = 0; i < 5; i++) tick();
        chk("stuck_ack_held", {31'd0, o_ack}, 32'd1);
        chk("stuck_op1", o_core_op1, 32'h0011);
        chk("stuck_no_err", {31'd0, o_err}, 32'd0);
        i_en = 1'b0;
        tick();
        chk("stuck_ackdrop", {31'd0, o_ack}, 32'd0);
        send(LD2, 32'h0022, "t2_ld2");
        send(INFO, 32'h0007, "t2_info");
        send(STORE, 32'h0033, "t2_store");
        chk("t2_start", {31'd0, o_core_start}, 32'd1);
        chk("t2_ops", {o_core_op1, o_core_op2}, 32'h0011_0022);
        chk("t2_info_wb", {8'd0, o_core_info, o_core_wb}, 32'h0007_0033);
        tick();
        finish_task("t2");

        // Async reset in RUN clears everything without a clock edge
        load_task(32'h0044, 32'h0055, 32'h0066, 32'h0077, "t3");
        tick();
        i_rstn = 1'b0;
        #1;
        chk("rst_run_outs", {o_ack, o_busy, o_finish, o_core_start, o_err}, 32'd0);
        chk("rst_run_op1", o_core_op1, 32'd0);
        tick();
        i_rstn = 1'b1;
        tick();
        send(LD1, 32'h0101, "post_rst_ld1");
        chk("post_rst_op1", o_core_op1, 32'h0101);

        // Out-of-order first phase is a sticky error with no ack
        do_reset();
        i_instr.kind = INFO; i_instr.payload = 32'h0005; i_en = 1'b1;
        tick();
        chk("ooo_err", {31'd0, o_err}, 32'd1);
        chk("ooo_noack", {31'd0, o_ack}, 32'd0);
        chk("ooo_nobusy", {31'd0, o_busy}, 32'd0);
        i_en = 1'b0;
        tick();
        chk("ooo_err_sticky", {31'd0, o_err}, 32'd1);
        do_reset();
        chk("ooo_err_rst", {31'd0, o_err}, 32'd0);
        load_task(32'h0A00, 32'h0B00, 32'h00C0, 32'h0D00, "rec");
        tick();
        finish_task("rec");

`ifdef SIMD_FE_TIMEOUT_EN
        load_task(32'h0001, 32'h0002, 32'h0003, 32'h0004, "tmo");
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_not_yet", {o_finish, o_err}, 32'd0);
        tick();
        chk("tmo_finish", {31'd0, o_finish}, 32'd1);
        chk("tmo_err", {31'd0, o_err}, 32'd1);
        i_finish_ack = 1'b1;
        tick();
        i_finish_ack = 1'b0;
        chk("tmo_reclaim", {o_finish, o_busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_proc_frontend.md
Name: simd_proc_frontend

Overview:
- Per-processor receive stage directly downstream of the issuer. One instance per SIMD processor slot; PROC_COUNT instances total.
- Accepts the issuer's four-phase instruction delivery (LD1, LD2, INFO, STORE) over a level enable/ack handshake, then latches operand, info and writeback fields.
- Launches the SIMD core and reports busy/finish back to the issuer, holding finish until the issuer acknowledges it.

Parameters:
- ADDR_W, 16, width of operand and writeback addresses carried in the instruction payload.
- INFO_W, 8, width of the op/info field delivered in the INFO phase.
- TIMEOUT_CYC, 1024, core watchdog limit in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_en  in  1  issuer enable for this slot (one bit of issuer o_en_proc)
- i_instr  in  instr_t  phase type plus payload from the issuer
- o_ack  out  1  receipt acknowledge (to issuer i_ack_proc bit)
- o_busy  out  1  slot occupied (to issuer i_busy_proc bit)
- o_finish  out  1  task complete (to issuer i_finish_proc bit)
- i_finish_ack  in  1  issuer finish acknowledge (issuer o_ack_proc bit)
- o_core_start  out  1  single-cycle core launch pulse
- o_core_op1  out  ADDR_W  operand-1 address
- o_core_op2  out  ADDR_W  operand-2 address
- o_core_info  out  INFO_W  operation/info field
- o_core_wb  out  ADDR_W  writeback address
- i_core_done  in  1  single-cycle core completion pulse
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, state IDLE, phase pointer = LD1, all latched fields 0.
- Reset is asynchronous; asserting it mid-task aborts the task with no finish.
- States: IDLE, RX, ACK_HOLD, START, RUN, DONE.
- Handshake (four-phase level):
  - In IDLE or RX, i_en==1 with i_instr.kind equal to the expected phase → latch the payload, set o_ack=1, go to ACK_HOLD.
  - o_ack stays high until i_en is sampled 0, then drops in the next cycle.
  - An instruction is never captured twice while i_en remains high.
- Phase order is fixed: LD1→op1, LD2→op2, INFO→info, STORE→wb.
  - Wrong kind: set o_err, do not ack, stay in the current state.
  - o_err clears only on reset.
- Busy: o_busy rises in the cycle after LD1 is captured and stays high until the cycle after i_finish_ack is sampled in DONE.
- Start: after the STORE ack completes (i_en low), go to START. o_core_start pulses for exactly one cycle, then RUN. Core outputs stay stable from START until leaving DONE.
- RUN: i_core_done → DONE, o_finish=1 in the next cycle.
- i_core_done outside RUN is ignored.
- DONE: o_finish is held until i_finish_ack==1. Then o_finish=0, o_busy=0, phase pointer = LD1, IDLE.
- i_finish_ack outside DONE is ignored.
- i_en in START/RUN/DONE is ignored (no ack).
- Latency: LD1 capture→o_ack is 1 cycle; i_en low→o_ack low is 1 cycle; i_core_done→o_finish is 1 cycle.
- Payload slicing: the low ADDR_W or INFO_W bits of the payload are used; upper bits are ignored.

Optional Feature:
- Macro SIMD_FE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on START and increments in RUN.
  - Reaching TIMEOUT_CYC without i_core_done → set o_err and enter DONE. o_finish is raised so the issuer can reclaim the slot.
- Undefined: no counter; RUN waits indefinitely.

Decomposition:
- Shared package (alongside defines.sv):
  - instr_kind_e {LD1=2'd0, LD2=2'd1, INFO=2'd2, STORE=2'd3}
  - instr_t {instr_kind_e kind; logic [`INSTR_PAYLOAD_W-1:0] payload}
  - frontend state enum
- Natural sub-module: simd_fe_handshake, a small four-phase receiver (capture strobe, ack hold, en-low detect) reused by the main FSM.

Test Plan:
- Nominal sequence: LD1 0x0010, LD2 0x0020, INFO 0x05, STORE 0x0030, each en held until ack → o_ack high 1 cycle after each en; o_core_start 1-cycle pulse; op1/op2/info/wb = 0x0010/0x0020/0x05/0x0030; o_busy=1.
- Stuck enable: keep i_en high 5 cycles after LD1 ack → only one capture, o_ack stays high, pointer stays at LD2; i_en low → o_ack low next cycle.
- Out-of-order: send INFO first → o_err=1, no ack, o_busy=0; after reset, a normal sequence succeeds.
- Finish handshake: i_core_done in RUN → o_finish=1 next cycle, held 4 cycles until i_finish_ack → o_finish=0, o_busy=0, IDLE; a second task then completes.
- Reset mid-RUN: i_rstn low → all outputs 0 immediately; new LD1 accepted after release.
- SIMD_FE_TIMEOUT_EN with TIMEOUT_CYC=8, no i_core_done → o_err=1 and o_finish=1 exactly 8 cycles after START.
